// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the IF-stage fetch controller.
//   fetch_state_e : sequencer states (IDLE, RUN, DRAIN, HALT)
//   PC_STEP       : byte increment between sequential instructions
//   NOP           : instruction value presented when nothing is valid
//   word_index()  : byte PC -> instruction memory word index
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  function automatic logic [31:0] word_index(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Bundle of every non-clock signal of the fetch controller.
//   slave  : seen from fetch_ctrl (takes control, redirect and memory data,
//            drives the memory address, the IF/ID outputs and status)
//   master : seen from the surrounding pipeline / instruction memory
// Signals:
//   start, halt_req      sequencer control pulses
//   id_stall             ID cannot take this cycle's instruction
//   redirect_vld/_pc     taken branch/jump and its byte target
//   imem_addr/imem_data  word index out, read data back one cycle later
//   if_valid/instr/pc    instruction handed to IF/ID
//   running              sequencer in RUN or DRAIN
//   fetch_count          accepted-instruction counter
//   addr_err, align_err  sticky error flags
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;

  logic        start;
  logic        halt_req;
  logic        id_stall;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        running;
  logic [31:0] fetch_count;
  logic        addr_err;
  logic        align_err;

  modport slave (
    input  start, halt_req, id_stall, redirect_vld, redirect_pc, imem_data,
    output imem_addr, if_valid, if_instr, if_pc, running, fetch_count,
           addr_err, align_err
  );

  modport master (
    output start, halt_req, id_stall, redirect_vld, redirect_pc, imem_data,
    input  imem_addr, if_valid, if_instr, if_pc, running, fetch_count,
           addr_err, align_err
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf
// One-entry holding register for an instruction that ID could not accept.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture d_instr/d_pc and mark the entry valid
//   clr               drop the entry (wins over load)
//   d_instr, d_pc     instruction and byte PC to capture
//   vld, instr, pc    held entry
// ---------------------------------------------------------------------------
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clr,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  output logic        vld,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  logic        vld_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg   <= 1'b0;
      instr_reg <= NOP;
      pc_reg    <= RESET_PC;
    end else if (clr) begin
      vld_reg   <= 1'b0;
    end else if (load) begin
      vld_reg   <= 1'b1;
      instr_reg <= d_instr;
      pc_reg    <= d_pc;
    end
  end

  assign vld   = vld_reg;
  assign instr = instr_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Program-counter sequencer for the IF stage. Issues word addresses to a
// synchronous instruction memory (one cycle read latency) and hands
// instruction + byte PC to the IF/ID register, with a one-entry hold buffer
// for ID stalls, branch/jump redirect with squash, a start/halt sequencer and
// sticky error flags.
// Parameters:
//   RESET_PC    byte PC loaded on reset
//   IMEM_DEPTH  memory depth in words; issuing a word index >= depth flags
//               addr_err (the fetch still proceeds)
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   bus         fetch_ctrl_if.slave (control, redirect, memory, IF/ID, status)
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.slave bus
);

  fetch_state_e state_reg, state_next;

  logic [31:0] pc_reg, pc_next;
  logic        fetch_vld_reg;   // a memory word for fetch_pc_reg arrives this cycle
  logic [31:0] fetch_pc_reg;
  logic [31:0] fetch_count_reg;
  logic        addr_err_reg;
  logic        align_err_reg;

  logic        hold_vld;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        hold_load;
  logic        hold_clr;
  logic        hold_keep;

  logic        issue;
  logic        advance;
  logic        any_vld;
  logic [31:0] word_idx;

  assign word_idx = word_index(pc_reg);
  assign issue    = (state_reg == RUN) && !bus.redirect_vld;

  // The word on imem_data is parked when ID stalls and nothing is held yet.
  assign hold_load = fetch_vld_reg && !hold_vld && bus.id_stall && !bus.redirect_vld;
  // Redirect squashes the held word; otherwise it leaves once ID accepts it.
  assign hold_clr  = bus.redirect_vld || (hold_vld && !bus.id_stall);
  assign hold_keep = hold_vld && bus.id_stall;

  // The word issued now is thrown away next cycle whenever the hold buffer
  // will be the one presenting; in that case pc_reg must stay put so the same
  // address is issued again. In every other case the issued word will be
  // shown, so the PC moves on. This also steps the PC in the cycle the hold
  // entry is released, which keeps the in-flight word and pc_reg one apart.
  assign advance = issue && !hold_load && !hold_keep;

  fetch_hold_buf #(
    .RESET_PC (RESET_PC)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .clr     (hold_clr),
    .d_instr (bus.imem_data),
    .d_pc    (fetch_pc_reg),
    .vld     (hold_vld),
    .instr   (hold_instr),
    .pc      (hold_pc)
  );

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    // A redirect freezes the sequencer for that cycle.
    if (!bus.redirect_vld) begin
      case (state_reg)
        IDLE:    if (bus.start) state_next = RUN;
        RUN:     if (bus.halt_req) state_next = DRAIN;  // halt beats start
        DRAIN:   if (!hold_vld && !fetch_vld_reg) state_next = HALT;
        HALT:    if (bus.start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------- program counter ----------------
  always_comb begin
    pc_next = pc_reg;
    if (bus.redirect_vld) begin
      pc_next = {bus.redirect_pc[31:2], 2'b00};
    end else if (advance) begin
      pc_next = pc_reg + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      fetch_vld_reg <= 1'b0;
      fetch_pc_reg  <= RESET_PC;
    end else begin
      pc_reg        <= pc_next;
      fetch_vld_reg <= issue;
      fetch_pc_reg  <= pc_reg;
    end
  end

  // ---------------- counters and sticky flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_reg <= 32'd0;
      addr_err_reg    <= 1'b0;
      align_err_reg   <= 1'b0;
    end else begin
      if (bus.if_valid && !bus.id_stall) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (issue && (word_idx >= IMEM_DEPTH)) begin
        addr_err_reg <= 1'b1;
      end
      if (bus.redirect_vld && (bus.redirect_pc[1:0] != 2'b00)) begin
        align_err_reg <= 1'b1;
      end
    end
  end

  // ---------------- outputs ----------------
  assign any_vld = hold_vld || fetch_vld_reg;

  assign bus.imem_addr   = word_idx;
  assign bus.if_valid    = any_vld && !bus.redirect_vld;
  // Instruction reads as NOP when nothing is in flight so that idle and reset
  // do not leak stale memory data onto IF/ID.
  assign bus.if_instr    = !any_vld ? NOP : (hold_vld ? hold_instr : bus.imem_data);
  assign bus.if_pc       = hold_vld ? hold_pc : fetch_pc_reg;
  assign bus.running     = (state_reg == RUN) || (state_reg == DRAIN);
  assign bus.fetch_count = fetch_count_reg;
  assign bus.addr_err    = addr_err_reg;
  assign bus.align_err   = align_err_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Memory model returns word index + 1 for
// every address, one cycle after the address is presented.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  typedef struct {
    bit          start;
    bit          halt_req;
    bit          id_stall;
    bit          redirect_vld;
    logic [31:0] redirect_pc;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    bit          exp_running;
  } vec_t;

  localparam int NVEC = 22;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: word i holds i+1, registered read.
  always_ff @(posedge clk) begin
    bus.imem_data <= bus.imem_addr + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit st, input bit hr, input bit stl, input bit rv,
                              input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                              input logic [31:0] ein, input bit er);
    vec_t v;
    v.start = st; v.halt_req = hr; v.id_stall = stl; v.redirect_vld = rv;
    v.redirect_pc = rpc; v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ein;
    v.exp_running = er;
    return v;
  endfunction

  task automatic drive(input bit st, input bit hr, input bit stl, input bit rv,
                       input logic [31:0] rpc);
    bus.start        = st;
    bus.halt_req     = hr;
    bus.id_stall     = stl;
    bus.redirect_vld = rv;
    bus.redirect_pc  = rpc;
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled 3
  // units later, well before the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".if_valid"},    {31'd0, bus.if_valid}, 32'd0);
    check({tag, ".if_instr"},    bus.if_instr, 32'd0);
    check({tag, ".if_pc"},       bus.if_pc, 32'd0);
    check({tag, ".running"},     {31'd0, bus.running}, 32'd0);
    check({tag, ".fetch_count"}, bus.fetch_count, 32'd0);
    check({tag, ".addr_err"},    {31'd0, bus.addr_err}, 32'd0);
    check({tag, ".align_err"},   {31'd0, bus.align_err}, 32'd0);
    check({tag, ".imem_addr"},   bus.imem_addr, 32'd0);
  endtask

  initial begin
    //              st hr stl rv rpc      ev pc       instr    run
    vecs[0]  = mk(1, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  0); // start in IDLE
    vecs[1]  = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  1); // first issue
    vecs[2]  = mk(0, 0, 0, 0, 32'h00, 1, 32'h00, 32'd1,  1);
    vecs[3]  = mk(0, 0, 0, 0, 32'h00, 1, 32'h04, 32'd2,  1);
    vecs[4]  = mk(0, 0, 1, 0, 32'h00, 1, 32'h08, 32'd3,  1); // stall starts
    vecs[5]  = mk(0, 0, 1, 0, 32'h00, 1, 32'h08, 32'd3,  1);
    vecs[6]  = mk(0, 0, 1, 0, 32'h00, 1, 32'h08, 32'd3,  1);
    vecs[7]  = mk(0, 0, 0, 0, 32'h00, 1, 32'h08, 32'd3,  1); // hold released
    vecs[8]  = mk(0, 0, 0, 0, 32'h00, 1, 32'h0C, 32'd4,  1);
    vecs[9]  = mk(0, 0, 0, 1, 32'h20, 0, 32'h00, 32'd0,  1); // redirect at 0x10
    vecs[10] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  1); // bubble
    vecs[11] = mk(0, 0, 0, 0, 32'h00, 1, 32'h20, 32'd9,  1);
    vecs[12] = mk(0, 0, 1, 0, 32'h00, 1, 32'h24, 32'd10, 1); // capture 0x24
    vecs[13] = mk(0, 0, 1, 1, 32'h10, 0, 32'h00, 32'd0,  1); // redirect over hold
    vecs[14] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  1);
    vecs[15] = mk(0, 0, 0, 0, 32'h00, 1, 32'h10, 32'd5,  1);
    vecs[16] = mk(0, 1, 0, 0, 32'h00, 1, 32'h14, 32'd6,  1); // halt at 0x14
    vecs[17] = mk(0, 0, 0, 0, 32'h00, 1, 32'h18, 32'd7,  1); // drained word
    vecs[18] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  1);
    vecs[19] = mk(1, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  0); // HALT, restart
    vecs[20] = mk(0, 0, 0, 0, 32'h00, 0, 32'h00, 32'd0,  1);
    vecs[21] = mk(0, 0, 0, 0, 32'h00, 1, 32'h1C, 32'd8,  1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    check_reset_outputs("reset");
    $display("reset released: if_valid=%0b if_pc=%h running=%0b", bus.if_valid, bus.if_pc,
             bus.running);

    for (int i = 0; i < NVEC; i++) begin
      next_cycle();
      drive(vecs[i].start, vecs[i].halt_req, vecs[i].id_stall, vecs[i].redirect_vld,
            vecs[i].redirect_pc);
      #3;
      check($sformatf("vec%0d.if_valid", i), {31'd0, bus.if_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d.running", i), {31'd0, bus.running}, {31'd0, vecs[i].exp_running});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d.if_pc", i), bus.if_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d.if_instr", i), bus.if_instr, vecs[i].exp_instr);
      end
      $display("vec %0d: stall=%0b redir=%0b valid=%0b pc=%h instr=%h running=%0b", i,
               vecs[i].id_stall, vecs[i].redirect_vld, bus.if_valid, bus.if_pc, bus.if_instr,
               bus.running);
    end

    // Misaligned redirect; accepted count covers 9 delivered instructions.
    next_cycle();
    drive(0, 0, 0, 1, 32'h3FE);
    #3;
    check("count.after_table", bus.fetch_count, 32'd9);
    check("align.before", {31'd0, bus.align_err}, 32'd0);
    check("addr.before", {31'd0, bus.addr_err}, 32'd0);
    $display("seq redirect 0x3FE: count=%0d align_err=%0b", bus.fetch_count, bus.align_err);

    next_cycle();
    drive(0, 0, 0, 0, 32'h0);
    #3;
    check("align.sticky", {31'd0, bus.align_err}, 32'd1);
    check("mis.bubble", {31'd0, bus.if_valid}, 32'd0);
    check("mis.imem_addr", bus.imem_addr, 32'h0FF);
    $display("seq bubble: imem_addr=%h align_err=%0b", bus.imem_addr, bus.align_err);

    next_cycle();
    #3;
    check("mis.if_valid", {31'd0, bus.if_valid}, 32'd1);
    check("mis.if_pc", bus.if_pc, 32'h3FC);
    check("mis.if_instr", bus.if_instr, 32'h100);
    check("edge.imem_addr", bus.imem_addr, 32'h100);
    check("addr.last_word_ok", {31'd0, bus.addr_err}, 32'd0);
    $display("seq last word: pc=%h instr=%h addr_err=%0b", bus.if_pc, bus.if_instr,
             bus.addr_err);

    next_cycle();
    drive(0, 0, 1, 0, 32'h0);
    #3;
    check("addr.sticky", {31'd0, bus.addr_err}, 32'd1);
    check("oob.if_pc", bus.if_pc, 32'h400);
    check("oob.if_instr", bus.if_instr, 32'h101);
    $display("seq out of range: pc=%h addr_err=%0b", bus.if_pc, bus.addr_err);

    next_cycle();
    #3;
    check("oob.held_valid", {31'd0, bus.if_valid}, 32'd1);
    check("oob.held_pc", bus.if_pc, 32'h400);
    // Reset between clock edges, while the hold buffer is occupied.
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    $display("seq async reset: if_valid=%0b if_pc=%h count=%0d", bus.if_valid, bus.if_pc,
             bus.fetch_count);
    drive(0, 0, 0, 0, 32'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    #3;
    check("post_rst.running", {31'd0, bus.running}, 32'd0);
    check("post_rst.if_valid", {31'd0, bus.if_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
